// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master.
// Provides the controller state encoding and the helpers that derive
// clock polarity/phase from SPI_MODE and the chip-select index width
// from NUM_CS.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_e;

  // SPI_MODE is {CPOL,CPHA}
  function automatic logic get_cpol(input int mode);
    return mode[1];
  endfunction

  function automatic logic get_cpha(input int mode);
    return mode[0];
  endfunction

  function automatic int cs_width(input int num_cs);
    return (num_cs <= 1) ? 1 : $clog2(num_cs);
  endfunction

endpackage

// File: rtl/spi_master_gen_if.sv
// Word-level handshake between the on-chip producer/consumer and the
// SPI master.
//   tx_data_i / tx_cs_sel_i / tx_last_i / tx_valid_i : word request
//   tx_ready_o                                       : master can accept
//   rx_data_o / rx_valid_o                           : received word, 1-cycle strobe
// Signal suffixes are from the SPI master's point of view.
// modport master : producer/consumer side
// modport slave  : SPI master block side
interface spi_master_gen_if #(
  parameter int DATA_W = 8,
  parameter int CS_W   = 1
);
  logic [DATA_W-1:0] tx_data_i;
  logic [CS_W-1:0]   tx_cs_sel_i;
  logic              tx_last_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;

  modport master (
    output tx_data_i, tx_cs_sel_i, tx_last_i, tx_valid_i,
    input  tx_ready_o, rx_data_o, rx_valid_o
  );

  modport slave (
    input  tx_data_i, tx_cs_sel_i, tx_last_i, tx_valid_i,
    output tx_ready_o, rx_data_o, rx_valid_o
  );
endinterface

// File: rtl/spi_clk_div.sv
// Clock divider producing one tick every RATIO enabled cycles.
//   clk_i     : system clock
//   reset_l_i : asynchronous active-low reset
//   clr_i     : synchronous clear of the count
//   en_i      : count enable
//   tick_o    : high on the enabled cycle where the count is RATIO-1
module spi_clk_div #(
  parameter int RATIO = 4
) (
  input  logic clk_i,
  input  logic reset_l_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = $clog2(RATIO) + 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master with multi-slave chip selects and bursts.
//   clk_i, reset_l_i : clock, asynchronous active-low reset
//   bus              : word handshake (tx request, tx_ready, rx word/strobe)
//   busy_o           : high whenever the controller is not IDLE
//   spi_clk_o        : SCLK, idles at CPOL
//   spi_mosi_o       : serial data out
//   spi_miso_i       : serial data in (slave guarantees setup to clk_i)
//   spi_cs_n_o       : active-low chip selects, one per slave
// A word is framed as SETUP (CS low, SCLK idle), SHIFT (2*DATA_W SCLK
// edges), then WAIT (CS held for the next burst word) or HOLD+GAP.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int SPI_MODE  = 0,
  parameter int CLK_RATIO = 4,
  parameter int DATA_W    = 8,
  parameter int NUM_CS    = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk_i,
  input  logic              reset_l_i,
  spi_master_gen_if.slave   bus,
  output logic              busy_o,
  output logic              spi_clk_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic [NUM_CS-1:0] spi_cs_n_o
);
  localparam logic CPOL  = get_cpol(SPI_MODE);
  localparam logic CPHA  = get_cpha(SPI_MODE);
  localparam int   EDGES = 2 * DATA_W;
  localparam int   EW    = $clog2(EDGES);
  localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES - 1);

  generate
    if (SPI_MODE < 0 || SPI_MODE > 3 || CLK_RATIO < 1 || DATA_W < 2 || NUM_CS < 1) begin : g_bad_param
      $error("spi_master_gen: illegal parameter combination");
    end
  endgenerate

  state_e              state_q;
  logic                sclk_q;
  logic                mosi_q;
  logic [NUM_CS-1:0]   cs_n_q;
  logic [DATA_W-1:0]   tx_sh_q;
  logic [DATA_W-1:0]   rx_sh_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                last_q;
  logic [EW-1:0]       edge_cnt_q;

  logic                ready;
  logic                accept;
  logic                div_en;
  logic                tick;
  logic                lead_edge;
  logic                sample_now;
  logic                final_edge;
  logic                advance_now;
  logic [DATA_W-1:0]   rx_in;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  assign ready  = (state_q == IDLE) || (state_q == WAIT);
  assign accept = bus.tx_valid_i && ready;
  assign div_en = (state_q == SETUP) || (state_q == SHIFT) ||
                  (state_q == HOLD)  || (state_q == GAP);

  // The divider is held clear outside the timed states; every timed state
  // is left on a tick, so the count is always zero on state entry.
  spi_clk_div #(.RATIO(CLK_RATIO)) u_div (
    .clk_i    (clk_i),
    .reset_l_i(reset_l_i),
    .clr_i    (!div_en),
    .en_i     (div_en),
    .tick_o   (tick)
  );

  // Edge 0 (counting from zero) is a leading edge, so even counts lead.
  assign lead_edge   = !edge_cnt_q[0];
  assign final_edge  = (edge_cnt_q == LAST_EDGE);
  assign sample_now  = CPHA ? !lead_edge : lead_edge;
  assign advance_now = CPHA ? lead_edge : (!lead_edge && !final_edge);
  assign rx_in = (LSB_FIRST != 0) ? {spi_miso_i, rx_sh_q[DATA_W-1:1]}
                                  : {rx_sh_q[DATA_W-2:0], spi_miso_i};

  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      state_q    <= IDLE;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE, WAIT: begin
          if (accept) begin
            last_q     <= bus.tx_last_i;
            edge_cnt_q <= '0;
            // CPHA=0 presents the first bit before the first SCLK edge.
            if (!CPHA) begin
              mosi_q  <= first_bit(bus.tx_data_i);
              tx_sh_q <= shift_out(bus.tx_data_i);
            end else begin
              tx_sh_q <= bus.tx_data_i;
            end
            // Slave selection is only taken at the start of a burst;
            // an out-of-range index leaves every select high.
            if (state_q == IDLE) begin
              for (int i = 0; i < NUM_CS; i++) begin
                cs_n_q[i] <= (int'(bus.tx_cs_sel_i) != i);
              end
            end
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (tick) state_q <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sclk_q     <= ~sclk_q;
            edge_cnt_q <= edge_cnt_q + 1'b1;
            if (sample_now) rx_sh_q <= rx_in;
            if (advance_now) begin
              mosi_q  <= first_bit(tx_sh_q);
              tx_sh_q <= shift_out(tx_sh_q);
            end
            if (final_edge) begin
              // With CPHA=1 the final edge is also the last sample.
              rx_data_q  <= sample_now ? rx_in : rx_sh_q;
              rx_valid_q <= 1'b1;
              state_q    <= last_q ? HOLD : WAIT;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n_q  <= '1;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (tick) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready_o = ready;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign busy_o         = (state_q != IDLE);
  assign spi_clk_o      = sclk_q;
  assign spi_mosi_o     = mosi_q;
  assign spi_cs_n_o     = cs_n_q;
endmodule

// File: tb/tb_spi_master_gen.sv
// Directed checks of spi_master_gen across three configurations:
//   u0: mode 0, 8-bit, ratio 2, 3 selects, MISO looped to MOSI
//   u1: mode 3, 8-bit, ratio 3, 1 select, slave model returning 0x3C
//   u2: mode 1, 16-bit LSB first, ratio 1, 1 select, looped
module tb_spi_master_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- u0 ----------------
  spi_master_gen_if #(.DATA_W(8), .CS_W(2)) bus0 ();
  logic       busy0, sclk0, mosi0, miso0;
  logic [2:0] cs0;
  assign miso0 = mosi0;

  spi_master_gen #(.SPI_MODE(0), .CLK_RATIO(2), .DATA_W(8), .NUM_CS(3), .LSB_FIRST(0)) u0 (
    .clk_i(clk), .reset_l_i(rst_n), .bus(bus0), .busy_o(busy0),
    .spi_clk_o(sclk0), .spi_mosi_o(mosi0), .spi_miso_i(miso0), .spi_cs_n_o(cs0)
  );

  // ---------------- u1 ----------------
  spi_master_gen_if #(.DATA_W(8), .CS_W(1)) bus1 ();
  logic       busy1, sclk1, mosi1, miso1;
  logic [0:0] cs1;

  spi_master_gen #(.SPI_MODE(3), .CLK_RATIO(3), .DATA_W(8), .NUM_CS(1), .LSB_FIRST(0)) u1 (
    .clk_i(clk), .reset_l_i(rst_n), .bus(bus1), .busy_o(busy1),
    .spi_clk_o(sclk1), .spi_mosi_o(mosi1), .spi_miso_i(miso1), .spi_cs_n_o(cs1)
  );

  // ---------------- u2 ----------------
  spi_master_gen_if #(.DATA_W(16), .CS_W(1)) bus2 ();
  logic       busy2, sclk2, mosi2, miso2;
  logic [0:0] cs2;
  assign miso2 = mosi2;

  spi_master_gen #(.SPI_MODE(1), .CLK_RATIO(1), .DATA_W(16), .NUM_CS(1), .LSB_FIRST(1)) u2 (
    .clk_i(clk), .reset_l_i(rst_n), .bus(bus2), .busy_o(busy2),
    .spi_clk_o(sclk2), .spi_mosi_o(mosi2), .spi_miso_i(miso2), .spi_cs_n_o(cs2)
  );

  // Mode-3 slave: drives on falling SCLK, captures on rising SCLK.
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  initial miso1 = 1'b0;
  always @(negedge sclk1 or posedge cs1[0]) begin
    if (cs1[0]) begin
      sl_tx <= 8'h3C;
    end else begin
      miso1 <= sl_tx[7];
      sl_tx <= {sl_tx[6:0], 1'b0};
    end
  end
  always @(posedge sclk1) begin
    if (cs1[0] === 1'b0) sl_rx <= {sl_rx[6:0], mosi1};
  end

  // Per-cycle monitors, sampled on the falling clk_i edge.
  int tog0 = 0, rise0 = 0, rxv0 = 0, csl0 = 0, csact0 = 0, csodd0 = 0, rel101 = 0;
  logic       psclk0 = 1'b0;
  logic [2:0] pcs0 = 3'b111;
  always @(negedge clk) begin
    if (sclk0 !== psclk0) tog0 <= tog0 + 1;
    if (psclk0 === 1'b0 && sclk0 === 1'b1) rise0 <= rise0 + 1;
    if (bus0.rx_valid_o === 1'b1) rxv0 <= rxv0 + 1;
    if (cs0[0] === 1'b0) csl0 <= csl0 + 1;
    if (cs0 !== 3'b111) csact0 <= csact0 + 1;
    if (cs0 !== 3'b111 && cs0 !== 3'b101) csodd0 <= csodd0 + 1;
    if (pcs0 === 3'b101 && cs0 === 3'b111) rel101 <= rel101 + 1;
    psclk0 <= sclk0;
    pcs0   <= cs0;
  end

  int   viol1 = 0, rxv1 = 0;
  logic psclk1 = 1'b1, pmosi1 = 1'b0;
  always @(negedge clk) begin
    if (mosi1 !== pmosi1 && !(psclk1 === 1'b1 && sclk1 === 1'b0)) viol1 <= viol1 + 1;
    if (bus1.rx_valid_o === 1'b1) rxv1 <= rxv1 + 1;
    psclk1 <= sclk1;
    pmosi1 <= mosi1;
  end

  int         fall2 = 0;
  logic [3:0] seq2 = 4'h0;
  logic       psclk2 = 1'b0;
  always @(negedge clk) begin
    if (psclk2 === 1'b1 && sclk2 === 1'b0) begin
      if (fall2 < 4) seq2 <= {seq2[2:0], mosi2};
      fall2 <= fall2 + 1;
    end
    psclk2 <= sclk2;
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] d, input logic [1:0] s, input logic l);
    int n = 0;
    @(negedge clk);
    bus0.tx_data_i   = d;
    bus0.tx_cs_sel_i = s;
    bus0.tx_last_i   = l;
    bus0.tx_valid_i  = 1'b1;
    while (bus0.tx_ready_o !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("u0_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus0.tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    logic b;
    b = 1'b1;
    while (b && n < 1000) begin
      @(negedge clk);
      n++;
      case (which)
        0:       b = busy0;
        1:       b = busy1;
        default: b = busy2;
      endcase
    end
    if (n >= 1000) chk("idle_timeout", 32'(which), 32'hFFFF);
  endtask

  int t_rxv, t_rise, t_csl, t_tog, t_act, t_odd, t_rel, n;

  initial begin
    bus0.tx_data_i = '0; bus0.tx_cs_sel_i = '0; bus0.tx_last_i = 1'b0; bus0.tx_valid_i = 1'b0;
    bus1.tx_data_i = '0; bus1.tx_cs_sel_i = '0; bus1.tx_last_i = 1'b0; bus1.tx_valid_i = 1'b0;
    bus2.tx_data_i = '0; bus2.tx_cs_sel_i = '0; bus2.tx_last_i = 1'b0; bus2.tx_valid_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cs_n", 32'(cs0), 32'h7);
    chk("rst_sclk_m0", 32'(sclk0), 32'd0);
    chk("rst_sclk_m3", 32'(sclk1), 32'd1);
    chk("rst_mosi", 32'(mosi0), 32'd0);
    chk("rst_rx_data", 32'(bus0.rx_data_o), 32'd0);
    chk("rst_rx_valid", 32'(bus0.rx_valid_o), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ready", 32'(bus0.tx_ready_o), 32'd1);
    rst_n = 1'b1;
    settle();

    // 1: mode 0 single word, loopback
    t_csl = csl0; t_rise = rise0; t_rxv = rxv0;
    send0(8'hA5, 2'd0, 1'b1);
    wait_idle(0);
    settle();
    chk("t1_rx_data", 32'(bus0.rx_data_o), 32'hA5);
    chk("t1_rx_pulses", 32'(rxv0 - t_rxv), 32'd1);
    chk("t1_cs_low_cycles", 32'(csl0 - t_csl), 32'd36);
    chk("t1_sclk_rises", 32'(rise0 - t_rise), 32'd8);
    chk("t1_sclk_idle", 32'(sclk0), 32'd0);
    chk("t1_ready", 32'(bus0.tx_ready_o), 32'd1);

    // 2: mode 3 against slave model
    @(negedge clk);
    bus1.tx_data_i = 8'hC3; bus1.tx_cs_sel_i = 1'b0; bus1.tx_last_i = 1'b1; bus1.tx_valid_i = 1'b1;
    n = 0;
    while (bus1.tx_ready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    bus1.tx_valid_i = 1'b0;
    wait_idle(1);
    settle();
    chk("t2_slave_rx", 32'(sl_rx), 32'hC3);
    chk("t2_rx_data", 32'(bus1.rx_data_o), 32'h3C);
    chk("t2_rx_pulses", 32'(rxv1), 32'd1);
    chk("t2_sclk_idle", 32'(sclk1), 32'd1);
    chk("t2_mosi_edge_viol", 32'(viol1), 32'd0);

    // 3: three-word burst on select 1; sel on later words is ignored
    t_rxv = rxv0; t_csl = csl0; t_odd = csodd0; t_rel = rel101;
    send0(8'h11, 2'd1, 1'b0);
    send0(8'h22, 2'd0, 1'b0);
    send0(8'h33, 2'd2, 1'b1);
    wait_idle(0);
    settle();
    chk("t3_rx_pulses", 32'(rxv0 - t_rxv), 32'd3);
    chk("t3_cs_releases", 32'(rel101 - t_rel), 32'd1);
    chk("t3_cs_other", 32'(csodd0 - t_odd), 32'd0);
    chk("t3_cs0_low", 32'(csl0 - t_csl), 32'd0);
    chk("t3_rx_data", 32'(bus0.rx_data_o), 32'h33);

    // 4: 16-bit LSB first, mode 1, loopback
    @(negedge clk);
    bus2.tx_data_i = 16'h1234; bus2.tx_cs_sel_i = 1'b0; bus2.tx_last_i = 1'b1; bus2.tx_valid_i = 1'b1;
    n = 0;
    while (bus2.tx_ready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    bus2.tx_valid_i = 1'b0;
    wait_idle(2);
    settle();
    chk("t4_mosi_first4", 32'(seq2), 32'b0010);
    chk("t4_rx_data", 32'(bus2.rx_data_o), 32'h1234);
    chk("t4_sclk_falls", 32'(fall2), 32'd16);

    // 6: out-of-range select (3 with NUM_CS=3)
    t_act = csact0; t_tog = tog0; t_rxv = rxv0;
    send0(8'hC6, 2'd3, 1'b1);
    wait_idle(0);
    settle();
    chk("t6_cs_active", 32'(csact0 - t_act), 32'd0);
    chk("t6_sclk_edges", 32'(tog0 - t_tog), 32'd16);
    chk("t6_rx_pulses", 32'(rxv0 - t_rxv), 32'd1);
    chk("t6_rx_data", 32'(bus0.rx_data_o), 32'hC6);

    // 5: reset after the fifth SCLK edge
    t_tog = tog0; t_rxv = rxv0;
    send0(8'h77, 2'd0, 1'b1);
    n = 0;
    while ((tog0 - t_tog) < 5 && n < 200) begin settle(); n++; end
    if (n >= 200) chk("t5_edge_timeout", 32'(n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_async_cs_n", 32'(cs0), 32'h7);
    chk("t5_async_sclk", 32'(sclk0), 32'd0);
    chk("t5_async_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    chk("t5_no_rx_pulse", 32'(rxv0 - t_rxv), 32'd0);
    t_rxv = rxv0;
    send0(8'h5A, 2'd0, 1'b1);
    wait_idle(0);
    settle();
    chk("t5_after_rx_data", 32'(bus0.rx_data_o), 32'h5A);
    chk("t5_after_rx_pulses", 32'(rxv0 - t_rxv), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
